weight_fifo_fill_seq: RTL and testbench

Multi-tile weight-fill sequencer that streams weight rows from weight memory into the per-column weight FIFOs of the systolic array. It generalises single-tile fill in four ways: a run-time row/column tile shape, back-to-back multi-tile fills with an address stride, an optional diagonal (skewed) issue mode, and memory back-pressure. It sits between the top-level control FSM (start/done) and the weight memory read ports.

---
 rtl/tpu_ctrl_pkg.sv | 20 ++
 rtl/weight_lane_addr_gen.sv | 67 ++++++
 rtl/weight_fifo_fill_seq.sv | 176 +++++++++++++++++
 tb/tb_weight_fifo_fill_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_ctrl_pkg.sv
// Shared definitions for the TPU control slice.
//   fill_state_t : weight-fill sequencer states (IDLE / FILL / FIN)
//   ROW_CNT_W    : width of a row-count field for the default 16x16 array
//   COL_CNT_W    : width of a column-count field for the default array
//   STEP_W       : width of the per-tile step counter for the default array
package tpu_ctrl_pkg;

  localparam int DEF_ROWS  = 16;
  localparam int DEF_COLS  = 16;
  localparam int ROW_CNT_W = $clog2(DEF_ROWS) + 1;
  localparam int COL_CNT_W = $clog2(DEF_COLS) + 1;
  localparam int STEP_W    = $clog2(DEF_ROWS + DEF_COLS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FIN  = 2'd2
  } fill_state_t;

endpackage

// File: rtl/weight_lane_addr_gen.sv
// Combinational per-lane decode for the weight-fill sequencer.
// Maps the current step, tile base and tile shape to a lane activity mask
// and a packed vector of lane read addresses.
//   en        : in  - decode enable (sequencer is filling)
//   step      : in  - step within the current tile
//   tile_base : in  - base address of the current tile
//   rows      : in  - reads per lane per tile
//   cols      : in  - number of active lanes
//   skew      : in  - 1 = diagonal issue, lane c lags c steps
//   lane_mask : out - 1 per lane that issues a read at this step
//   lane_addr : out - lane c address at [c*ADDR_WIDTH +: ADDR_WIDTH], 0 if idle
module weight_lane_addr_gen
  import tpu_ctrl_pkg::*;
#(
  parameter int SYS_ARR_COLS = DEF_COLS,
  parameter int ADDR_WIDTH   = 8,
  parameter int ROW_W        = ROW_CNT_W,
  parameter int COL_W        = COL_CNT_W,
  parameter int STEP_WD      = STEP_W
) (
  input  logic                             en,
  input  logic [STEP_WD-1:0]               step,
  input  logic [ADDR_WIDTH-1:0]            tile_base,
  input  logic [ROW_W-1:0]                 rows,
  input  logic [COL_W-1:0]                 cols,
  input  logic                             skew,
  output logic [SYS_ARR_COLS-1:0]          lane_mask,
  output logic [SYS_ARR_COLS*ADDR_WIDTH-1:0] lane_addr
);

  // Common compare width: one bit wider than any operand so lane+rows
  // cannot overflow.
  localparam int MAX_A = (STEP_WD > ROW_W) ? STEP_WD : ROW_W;
  localparam int MAX_B = (MAX_A > COL_W) ? MAX_A : COL_W;
  localparam int EW    = MAX_B + 1;

  logic [EW-1:0] step_e;
  logic [EW-1:0] rows_e;
  logic [EW-1:0] cols_e;

  assign step_e = EW'(step);
  assign rows_e = EW'(rows);
  assign cols_e = EW'(cols);

  genvar gi;
  generate
    for (gi = 0; gi < SYS_ARR_COLS; gi++) begin : g_lane
      localparam logic [EW-1:0] LANE = EW'(gi);
      logic                  in_cols;
      logic                  in_window;
      logic                  active;
      logic [ADDR_WIDTH-1:0] offset;

      assign in_cols   = (LANE < cols_e);
      // Skewed lanes open their window c steps late and keep it for rows steps.
      assign in_window = skew ? ((step_e >= LANE) && (step_e < (LANE + rows_e)))
                              : (step_e < rows_e);
      assign offset    = skew ? ADDR_WIDTH'(step_e - LANE) : ADDR_WIDTH'(step_e);
      assign active    = en & in_cols & in_window;

      assign lane_mask[gi] = active;
      // Address addition wraps naturally at ADDR_WIDTH bits.
      assign lane_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] = active ? (tile_base + offset) : '0;
    end
  endgenerate

endmodule

// File: rtl/weight_fifo_fill_seq.sv
// Multi-tile weight-fill sequencer: streams weight rows from weight memory
// into the per-column weight FIFOs, one tile after another.
//   clk, reset        : clock, synchronous active-high reset
//   start             : begin a run (only looked at in IDLE)
//   cfg_*             : run configuration, captured when start is accepted
//   mem_ready         : memory accepts reads this cycle; 0 stalls everything
//   weightMem_rd_en   : per-lane read enable
//   weightMem_rd_addr : per-lane read address, lane c at [c*ADDR_WIDTH +: ADDR_WIDTH]
//   fifo_active       : pulse on the first issued read of each tile
//   tile_idx          : tile being filled (0 outside FILL)
//   busy              : high in FILL and FIN
//   done              : one-cycle pulse at run completion
module weight_fifo_fill_seq
  import tpu_ctrl_pkg::*;
#(
  parameter int SYS_ARR_ROWS   = 16,
  parameter int SYS_ARR_COLS   = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int TILE_CNT_WIDTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [ADDR_WIDTH-1:0]              cfg_base_addr,
  input  logic [$clog2(SYS_ARR_ROWS):0]      cfg_rows,
  input  logic [$clog2(SYS_ARR_COLS):0]      cfg_cols,
  input  logic [TILE_CNT_WIDTH-1:0]          cfg_num_tiles,
  input  logic [ADDR_WIDTH-1:0]              cfg_tile_stride,
  input  logic                               cfg_skew,
  input  logic                               mem_ready,
  output logic [SYS_ARR_COLS-1:0]            weightMem_rd_en,
  output logic [SYS_ARR_COLS*ADDR_WIDTH-1:0] weightMem_rd_addr,
  output logic                               fifo_active,
  output logic [TILE_CNT_WIDTH-1:0]          tile_idx,
  output logic                               busy,
  output logic                               done
);

  localparam int ROW_W   = $clog2(SYS_ARR_ROWS) + 1;
  localparam int COL_W   = $clog2(SYS_ARR_COLS) + 1;
  localparam int STEP_WD = $clog2(SYS_ARR_ROWS + SYS_ARR_COLS);
  localparam int SPAN_W  = STEP_WD + 1;
  localparam int TW1     = TILE_CNT_WIDTH + 1;

  localparam logic [SPAN_W-1:0]         SPAN_ONE = 1;
  localparam logic [SPAN_W-1:0]         SPAN_TWO = 2;
  localparam logic [STEP_WD-1:0]        STEP_ONE = 1;
  localparam logic [TILE_CNT_WIDTH-1:0] TILE_ONE = 1;
  localparam logic [TW1-1:0]            TW1_ONE  = 1;

  fill_state_t               state_q, state_d;
  logic [STEP_WD-1:0]        step_q, step_d;
  logic [TILE_CNT_WIDTH-1:0] tile_q, tile_d;
  logic [ADDR_WIDTH-1:0]     tile_base_q, tile_base_d;
  logic [ROW_W-1:0]          rows_q, rows_d;
  logic [COL_W-1:0]          cols_q, cols_d;
  logic [TILE_CNT_WIDTH-1:0] num_tiles_q, num_tiles_d;
  logic [ADDR_WIDTH-1:0]     stride_q, stride_d;
  logic                      skew_q, skew_d;

  logic                      in_fill;
  logic [SPAN_W-1:0]         span_m1;
  logic                      last_step;
  logic                      last_tile;
  logic [SYS_ARR_COLS-1:0]   lane_mask;

  assign in_fill = (state_q == FILL);

  // Index of the final step of a tile; only evaluated with rows,cols >= 1.
  assign span_m1   = skew_q ? (SPAN_W'(rows_q) + SPAN_W'(cols_q) - SPAN_TWO)
                            : (SPAN_W'(rows_q) - SPAN_ONE);
  assign last_step = ({1'b0, step_q} == span_m1);
  assign last_tile = (({1'b0, tile_q} + TW1_ONE) >= {1'b0, num_tiles_q});

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      step_q      <= '0;
      tile_q      <= '0;
      tile_base_q <= '0;
      rows_q      <= '0;
      cols_q      <= '0;
      num_tiles_q <= '0;
      stride_q    <= '0;
      skew_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      tile_q      <= tile_d;
      tile_base_q <= tile_base_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      num_tiles_q <= num_tiles_d;
      stride_q    <= stride_d;
      skew_q      <= skew_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    tile_d      = tile_q;
    tile_base_d = tile_base_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    num_tiles_d = num_tiles_q;
    stride_d    = stride_q;
    skew_d      = skew_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          rows_d      = cfg_rows;
          cols_d      = cfg_cols;
          num_tiles_d = cfg_num_tiles;
          stride_d    = cfg_tile_stride;
          skew_d      = cfg_skew;
          step_d      = '0;
          tile_d      = '0;
          tile_base_d = cfg_base_addr;
          // Empty shapes skip straight to completion.
          if ((cfg_rows == '0) || (cfg_cols == '0) || (cfg_num_tiles == '0)) begin
            state_d = FIN;
          end else begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (mem_ready) begin
          if (last_step) begin
            if (last_tile) begin
              state_d = FIN;
            end else begin
              tile_d      = tile_q + TILE_ONE;
              tile_base_d = tile_base_q + stride_q;
              step_d      = '0;
            end
          end else begin
            step_d = step_q + STEP_ONE;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  weight_lane_addr_gen #(
    .SYS_ARR_COLS (SYS_ARR_COLS),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .ROW_W        (ROW_W),
    .COL_W        (COL_W),
    .STEP_WD      (STEP_WD)
  ) u_lane_addr_gen (
    .en        (in_fill),
    .step      (step_q),
    .tile_base (tile_base_q),
    .rows      (rows_q),
    .cols      (cols_q),
    .skew      (skew_q),
    .lane_mask (lane_mask),
    .lane_addr (weightMem_rd_addr)
  );

  assign weightMem_rd_en = lane_mask & {SYS_ARR_COLS{mem_ready}};
  assign fifo_active     = in_fill & (step_q == '0) & mem_ready;
  assign tile_idx        = in_fill ? tile_q : '0;
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == FIN);

endmodule

// File: tb/tb_weight_fifo_fill_seq.sv
module tb_weight_fifo_fill_seq;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [7:0]   cfg_base_addr;
  logic [4:0]   cfg_rows;
  logic [4:0]   cfg_cols;
  logic [3:0]   cfg_num_tiles;
  logic [7:0]   cfg_tile_stride;
  logic         cfg_skew;
  logic         mem_ready;
  logic [15:0]  weightMem_rd_en;
  logic [127:0] weightMem_rd_addr;
  logic         fifo_active;
  logic [3:0]   tile_idx;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  // Expected read beats of one run, one entry per accepted step.
  logic [15:0]  q_mask[$];
  logic [127:0] q_addr[$];
  int           q_tile[$];
  bit           q_first[$];

  weight_fifo_fill_seq dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .cfg_base_addr     (cfg_base_addr),
    .cfg_rows          (cfg_rows),
    .cfg_cols          (cfg_cols),
    .cfg_num_tiles     (cfg_num_tiles),
    .cfg_tile_stride   (cfg_tile_stride),
    .cfg_skew          (cfg_skew),
    .mem_ready         (mem_ready),
    .weightMem_rd_en   (weightMem_rd_en),
    .weightMem_rd_addr (weightMem_rd_addr),
    .fifo_active       (fifo_active),
    .tile_idx          (tile_idx),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".rd_en"}, 256'(weightMem_rd_en), 256'(0));
    check({tag, ".rd_addr"}, 256'(weightMem_rd_addr), 256'(0));
    check({tag, ".fifo_active"}, 256'(fifo_active), 256'(0));
    check({tag, ".tile_idx"}, 256'(tile_idx), 256'(0));
    check({tag, ".busy"}, 256'(busy), 256'(0));
    check({tag, ".done"}, 256'(done), 256'(0));
  endtask

  // Enumerate every read beat of a run directly from the tile geometry.
  task automatic build_model(input logic [7:0] base, input logic [7:0] stride,
                             input int rows, input int cols, input int tiles, input bit skew);
    int n;
    int tb_base;
    int a;
    logic [15:0]  m;
    logic [127:0] v;
    q_mask.delete(); q_addr.delete(); q_tile.delete(); q_first.delete();
    if (rows == 0 || cols == 0 || tiles == 0) return;
    n = skew ? rows + cols - 1 : rows;
    for (int t = 0; t < tiles; t++) begin
      tb_base = (int'(base) + t * int'(stride)) % 256;
      for (int s = 0; s < n; s++) begin
        m = '0;
        v = '0;
        for (int c = 0; c < 16; c++) begin
          bit act;
          act = (c < cols) && (skew ? (s >= c && s < c + rows) : (s < rows));
          if (act) begin
            m[c] = 1'b1;
            a = (tb_base + (skew ? s - c : s)) % 256;
            v[c*8 +: 8] = a[7:0];
          end
        end
        q_mask.push_back(m);
        q_addr.push_back(v);
        q_tile.push_back(t);
        q_first.push_back(s == 0);
      end
    end
  endtask

  // mode 0: always ready; 1: random stalls; 2: stall in the 2nd and 3rd cycles.
  task automatic run_fill(input logic [7:0] base, input logic [7:0] stride,
                          input int rows, input int cols, input int tiles,
                          input bit skew, input int mode, input string name);
    int b;
    int cyc;
    bit finished;
    bit mr;
    logic [15:0]  e_en;
    logic [127:0] e_addr;
    logic         e_fa;
    logic [3:0]   e_tidx;
    logic         e_done;
    build_model(base, stride, rows, cols, tiles, skew);
    @(negedge clk);
    cfg_base_addr   = base;
    cfg_tile_stride = stride;
    cfg_rows        = 5'(rows);
    cfg_cols        = 5'(cols);
    cfg_num_tiles   = 4'(tiles);
    cfg_skew        = skew;
    start           = 1'b1;
    mem_ready       = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
    // Scramble config after acceptance; the run must not notice.
    cfg_base_addr   = 8'($urandom);
    cfg_tile_stride = 8'($urandom);
    cfg_rows        = 5'($urandom_range(0, 16));
    cfg_cols        = 5'($urandom_range(0, 16));
    cfg_num_tiles   = 4'($urandom);
    cfg_skew        = 1'($urandom);
    b = 0;
    cyc = 0;
    finished = 0;
    while (!finished && cyc < 2000) begin
      case (mode)
        0:       mr = 1'b1;
        1:       mr = ($urandom_range(0, 3) != 0);
        default: mr = !(cyc == 1 || cyc == 2);
      endcase
      mem_ready = mr;
      start = ($urandom_range(0, 7) == 0);
      #1;
      if (b < q_mask.size()) begin
        e_en   = mr ? q_mask[b] : 16'h0;
        e_addr = q_addr[b];
        e_fa   = mr && q_first[b];
        e_tidx = 4'(q_tile[b]);
        e_done = 1'b0;
        if (mr) b++;
      end else begin
        e_en   = '0;
        e_addr = '0;
        e_fa   = 1'b0;
        e_tidx = '0;
        e_done = 1'b1;
        finished = 1;
      end
      check({name, ".rd_en"}, 256'(weightMem_rd_en), 256'(e_en));
      check({name, ".rd_addr"}, 256'(weightMem_rd_addr), 256'(e_addr));
      check({name, ".fifo_active"}, 256'(fifo_active), 256'(e_fa));
      check({name, ".tile_idx"}, 256'(tile_idx), 256'(e_tidx));
      check({name, ".busy"}, 256'(busy), 256'(1));
      check({name, ".done"}, 256'(done), 256'(e_done));
      @(negedge clk);
      cyc++;
    end
    if (!finished) check({name, ".timeout"}, 256'(0), 256'(1));
    start = 1'b0;
    mem_ready = 1'b1;
    #1;
    check_idle({name, ".after"});
    $display("run %s rows=%0d cols=%0d tiles=%0d skew=%0d mode=%0d beats=%0d cycles=%0d",
             name, rows, cols, tiles, skew, mode, q_mask.size(), cyc);
  endtask

  task automatic reset_abort();
    @(negedge clk);
    cfg_base_addr   = 8'h20;
    cfg_tile_stride = 8'h10;
    cfg_rows        = 5'd8;
    cfg_cols        = 5'd4;
    cfg_num_tiles   = 4'd2;
    cfg_skew        = 1'b0;
    start           = 1'b1;
    mem_ready       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("abort.busy_before", 256'(busy), 256'(1));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle("abort.post_reset");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      check("abort.no_done", 256'(done), 256'(0));
      check("abort.no_busy", 256'(busy), 256'(0));
    end
    $display("run abort: reset during FILL");
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    mem_ready = 1'b0;
    cfg_base_addr = '0;
    cfg_tile_stride = '0;
    cfg_rows = '0;
    cfg_cols = '0;
    cfg_num_tiles = '0;
    cfg_skew = 1'b0;
    repeat (3) @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check_idle("reset");
    reset = 1'b0;

    run_fill(8'h10, 8'h00, 4, 3, 1, 1'b0, 0, "basic");
    run_fill(8'h00, 8'h00, 2, 3, 1, 1'b1, 0, "skew");
    run_fill(8'hFE, 8'h04, 3, 2, 2, 1'b0, 0, "wrap");
    run_fill(8'h10, 8'h00, 4, 3, 1, 1'b0, 2, "stall");
    run_fill(8'h40, 8'h08, 0, 3, 2, 1'b0, 0, "rows0");
    run_fill(8'h40, 8'h08, 3, 0, 2, 1'b1, 0, "cols0");
    run_fill(8'h40, 8'h08, 3, 3, 0, 1'b0, 0, "tiles0");
    run_fill(8'hF0, 8'h11, 16, 16, 2, 1'b1, 1, "full_skew");
    reset_abort();

    for (int r = 0; r < 40; r++) begin
      int tiles;
      tiles = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
      run_fill(8'($urandom), 8'($urandom), $urandom_range(0, 16), $urandom_range(0, 16),
               tiles, 1'($urandom), $urandom_range(0, 1), $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
